// File: rtl/sseg_pkg.sv
// Shared types and constants for the seven-segment scan controller.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
//
// Contents: FSM state enum, active-low 16-entry hex font (DP bit held off),
// dash/blank glyphs and the width of the BCD conversion result.
package sseg_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CONV   = 2'd1,
    COMMIT = 2'd2
  } state_e;

  // Ten BCD digits cover the full 32-bit unsigned range.
  localparam int BCD_W = 40;

  localparam logic [7:0] SEG_DASH  = 8'hBF;  // segment g only, DP off
  localparam logic [7:0] SEG_BLANK = 8'hFF;

  // Glyphs indexed by nibble value; bit0 = a .. bit6 = g, bit7 = DP (off).
  // Listed from entry 15 (F) down to entry 0.
  localparam logic [15:0][7:0] HEX_FONT = {
    8'h8E, 8'h86, 8'hA1, 8'hC6, 8'h83, 8'h88, 8'h90, 8'h80,
    8'hF8, 8'h82, 8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9, 8'hC0
  };

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential 32-bit binary to 40-bit BCD converter (shift-add-3).
// Latency: start cycle loads operands, then 32 shift cycles; bcd final after the cycle where done=1.
// Backpressure: start is ignored while a conversion runs; no stall input.
//
// Ports: clk, n_rst (async active-low), start (load bin), bin[31:0],
//        done (high during the final shift cycle), bcd[39:0] (result register).
module bin2bcd_seq
  import sseg_pkg::*;
(
  input  logic             clk,
  input  logic             n_rst,
  input  logic             start,
  input  logic [31:0]      bin,
  output logic             done,
  output logic [BCD_W-1:0] bcd
);

  logic [31:0]      bin_q;
  logic [4:0]       cnt_q;
  logic             run_q;
  logic [BCD_W-1:0] adj;

  // Add 3 to every digit >= 5 before the shift so it carries correctly.
  always_comb begin
    adj = bcd;
    for (int i = 0; i < BCD_W / 4; i++) begin
      if (bcd[4*i +: 4] >= 4'd5) begin
        adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
      end
    end
  end

  // done marks the 32nd shift; the result register holds it afterwards.
  assign done = run_q && (cnt_q == 5'd31);

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      bin_q <= '0;
      cnt_q <= '0;
      run_q <= 1'b0;
      bcd   <= '0;
    end else if (start && !run_q) begin
      bin_q <= bin;
      cnt_q <= '0;
      run_q <= 1'b1;
      bcd   <= '0;
    end else if (run_q) begin
      bcd   <= {adj[BCD_W-2:0], bin_q[31]};
      bin_q <= {bin_q[30:0], 1'b0};
      cnt_q <= cnt_q + 5'd1;
      if (done) begin
        run_q <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/sseg_scan_ctrl.sv
// Multiplexed seven-segment display controller with hex or decimal display.
// Latency: hex write visible next cycle; decimal write 34 cycles after wr_en; CA/AN registered (+1).
// Backpressure: wr_en while busy=1 is dropped (no queuing); outputs never stall.
//
// Ports: clk, n_rst (async active-low), wr_en/wr_data/dec_mode/dp_mask (write),
//        busy, ovf, SSEG_CA[7:0] (active-low cathodes), SSEG_AN[NUM_DIGITS-1:0] (active-low anodes).
// Build option: define SSEG_LZ_BLANK_EN to blank leading zero digits.
module sseg_scan_ctrl
  import sseg_pkg::*;
#(
  parameter int NUM_DIGITS  = 8,
  parameter int REFRESH_DIV = 100000
) (
  input  logic                  clk,
  input  logic                  n_rst,
  input  logic                  wr_en,
  input  logic [31:0]           wr_data,
  input  logic                  dec_mode,
  input  logic [NUM_DIGITS-1:0] dp_mask,
  output logic                  busy,
  output logic                  ovf,
  output logic [7:0]            SSEG_CA,
  output logic [NUM_DIGITS-1:0] SSEG_AN
);

  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int CNT_W = $clog2(REFRESH_DIV);

  state_e state_q, state_d;
  logic   conv_start, hex_load, commit;

  logic                  bcd_done;
  logic [BCD_W-1:0]      bcd_w;
  logic                  bcd_hi_nz;

  logic [31:0]           disp_q;
  logic [NUM_DIGITS-1:0] dp_q;
  logic [NUM_DIGITS-1:0] dp_pend_q;
  logic                  ovf_q;

  logic [CNT_W-1:0]      cnt_q;
  logic [IDX_W-1:0]      digit_idx;

  logic [3:0]            nib;
  logic                  lit;
  logic [7:0]            ca_d;

  bin2bcd_seq u_bin2bcd (
    .clk   (clk),
    .n_rst (n_rst),
    .start (conv_start),
    .bin   (wr_data),
    .done  (bcd_done),
    .bcd   (bcd_w)
  );

  // Any BCD digit beyond the displayed ones means the value does not fit.
  assign bcd_hi_nz = |(bcd_w >> (4 * NUM_DIGITS));

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    conv_start = 1'b0;
    hex_load   = 1'b0;
    commit     = 1'b0;
    case (state_q)
      IDLE: begin
        if (wr_en) begin
          if (dec_mode) begin
            conv_start = 1'b1;
            state_d    = CONV;
          end else begin
            hex_load = 1'b1;
          end
        end
      end
      CONV: begin
        if (bcd_done) state_d = COMMIT;
      end
      COMMIT: begin
        commit  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy = (state_q != IDLE);
  assign ovf  = ovf_q;

  // Display register: untouched while converting, loaded by hex write or commit.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      disp_q    <= '0;
      dp_q      <= '0;
      dp_pend_q <= '0;
      ovf_q     <= 1'b0;
    end else begin
      if (hex_load) begin
        disp_q <= wr_data;
        dp_q   <= dp_mask;
        ovf_q  <= 1'b0;
      end
      if (conv_start) begin
        dp_pend_q <= dp_mask;
      end
      if (commit) begin
        disp_q <= bcd_w[31:0];
        dp_q   <= dp_pend_q;
        ovf_q  <= bcd_hi_nz;
      end
    end
  end

  // Refresh divider and digit selector.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      cnt_q     <= '0;
      digit_idx <= '0;
    end else if (cnt_q == CNT_W'(REFRESH_DIV - 1)) begin
      cnt_q     <= '0;
      digit_idx <= (digit_idx == IDX_W'(NUM_DIGITS - 1)) ? '0 : digit_idx + 1'b1;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign nib = 4'(disp_q >> {digit_idx, 2'b00});

`ifdef SSEG_LZ_BLANK_EN
  localparam logic [32:0] ONE_33   = 33'd1;
  localparam logic [31:0] VIS_MASK = 32'((ONE_33 << (4 * NUM_DIGITS)) - 33'd1);
  logic [31:0] upper;
  // A digit stays lit if it or any displayed digit above it is nonzero.
  always_comb begin
    upper = (disp_q & VIS_MASK) >> {digit_idx, 2'b00};
    lit   = (digit_idx == '0) || (upper != '0);
  end
`else
  assign lit = 1'b1;
`endif

  always_comb begin
    if (ovf_q)    ca_d = SEG_DASH;
    else if (lit) ca_d = HEX_FONT[nib];
    else          ca_d = SEG_BLANK;
    if (!ovf_q && dp_q[digit_idx]) ca_d[7] = 1'b0;
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      SSEG_CA <= '1;
      SSEG_AN <= '1;
    end else begin
      SSEG_CA <= ca_d;
      SSEG_AN <= ~(NUM_DIGITS'(1) << digit_idx);
    end
  end

endmodule

// File: tb/tb_sseg_scan_ctrl.sv
// Testbench for sseg_scan_ctrl (NUM_DIGITS=8, REFRESH_DIV=4).
// Latency: n/a. Backpressure: n/a.
// Expected glyphs are pushed to a queue when a write is driven and popped as digits are scanned.
module tb_sseg_scan_ctrl;

  localparam int ND = 8;
  localparam int RD = 4;

  logic        clk = 1'b0;
  logic        n_rst;
  logic        wr_en;
  logic [31:0] wr_data;
  logic        dec_mode;
  logic [7:0]  dp_mask;
  logic        busy;
  logic        ovf;
  logic [7:0]  SSEG_CA;
  logic [7:0]  SSEG_AN;

  int checks = 0;
  int errors = 0;

  logic [7:0] exp_q[$];
  logic [7:0] font [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                            8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

  // Model of what is currently on the display.
  logic [31:0] cur_disp;
  logic [7:0]  cur_dp;
  logic        cur_ov;

  always #5 clk = ~clk;

  sseg_scan_ctrl #(.NUM_DIGITS(ND), .REFRESH_DIV(RD)) dut (
    .clk      (clk),
    .n_rst    (n_rst),
    .wr_en    (wr_en),
    .wr_data  (wr_data),
    .dec_mode (dec_mode),
    .dp_mask  (dp_mask),
    .busy     (busy),
    .ovf      (ovf),
    .SSEG_CA  (SSEG_CA),
    .SSEG_AN  (SSEG_AN)
  );

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  function automatic logic [7:0] exp_ca(input logic [31:0] disp, input logic [7:0] dp,
                                        input logic ov, input int d);
    logic [31:0] up;
    logic [7:0]  s;
    if (ov) return 8'hBF;
    up = disp >> (4 * d);
    s  = font[up[3:0]];
`ifdef SSEG_LZ_BLANK_EN
    if (d != 0 && up == 32'd0) s = 8'hFF;
`endif
    if (dp[d]) s[7] = 1'b0;
    return s;
  endfunction

  function automatic logic [31:0] dec_digits(input logic [31:0] v);
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < 8; i++) begin
      r[4*i +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  function automatic void push_display();
    for (int d = 0; d < ND; d++) exp_q.push_back(exp_ca(cur_disp, cur_dp, cur_ov, d));
  endfunction

  task automatic do_write(input logic [31:0] data, input logic dm, input logic [7:0] dp);
    @(negedge clk);
    wr_data  = data;
    dec_mode = dm;
    dp_mask  = dp;
    wr_en    = 1'b1;
    @(negedge clk);
    wr_en    = 1'b0;
  endtask

  // Gathers the cathode pattern shown for each digit 0..7 in one scan pass.
  task automatic collect_scan(output logic [7:0][7:0] ca, output bit to);
    to = 1'b0;
    ca = '0;
    repeat (2) @(negedge clk);
    for (int d = 0; d < ND; d++) begin
      int n = 0;
      while (SSEG_AN !== ~(8'd1 << d) && n < 100) begin
        @(negedge clk);
        n++;
      end
      if (n >= 100) to = 1'b1;
      ca[d] = SSEG_CA;
    end
  endtask

  task automatic test_reset();
    logic [7:0] e_an, e_ca;
    n_rst = 1'b0; wr_en = 1'b0; wr_data = '0; dec_mode = 1'b0; dp_mask = '0;
    repeat (3) @(negedge clk);
    checks++; if (SSEG_CA !== 8'hFF) begin errors++; $display("FAIL rst_ca: got %h expected ff", SSEG_CA); end
    checks++; if (SSEG_AN !== 8'hFF) begin errors++; $display("FAIL rst_an: got %h expected ff", SSEG_AN); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b expected 0", busy); end
    checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL rst_ovf: got %b expected 0", ovf); end
    cur_disp = '0; cur_dp = '0; cur_ov = 1'b0;
    // Each digit is held for RD cycles; sample k follows the k-th clock edge.
    for (int k = 1; k <= 9 * RD; k++) begin
      int dk = ((k - 1) / RD) % ND;
      exp_q.push_back(~(8'd1 << dk));
      exp_q.push_back(exp_ca(cur_disp, cur_dp, cur_ov, dk));
    end
    n_rst = 1'b1;
    for (int k = 1; k <= 9 * RD; k++) begin
      @(negedge clk);
      e_an = exp_q.pop_front();
      e_ca = exp_q.pop_front();
      checks++;
      if (SSEG_AN !== e_an || SSEG_CA !== e_ca) begin
        errors++;
        $display("FAIL scan_step%0d: got an=%h ca=%h expected an=%h ca=%h", k, SSEG_AN, SSEG_CA, e_an, e_ca);
      end
    end
  endtask

  task automatic test_hex(input logic [31:0] v, input logic [7:0] dp, input string name);
    logic [7:0][7:0] ca;
    bit to;
    logic [7:0] e;
    cur_disp = v; cur_dp = dp; cur_ov = 1'b0;
    push_display();
    do_write(v, 1'b0, dp);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL %s_busy: got %b expected 0", name, busy); end
    checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL %s_ovf: got %b expected 0", name, ovf); end
    collect_scan(ca, to);
    checks++; if (to) begin errors++; $display("FAIL %s_scan_timeout: got timeout expected all digits", name); end
    for (int d = 0; d < ND; d++) begin
      e = exp_q.pop_front();
      checks++;
      if (ca[d] !== e) begin errors++; $display("FAIL %s_digit%0d: got %h expected %h", name, d, ca[d], e); end
    end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL %s_busy_after: got %b expected 0", name, busy); end
  endtask

  // Decimal write, optionally followed 3 cycles later by a write that must be dropped.
  task automatic test_decimal(input logic [31:0] v, input logic [7:0] dp, input bit second_wr,
                              input string name);
    logic [7:0][7:0] ca;
    bit to;
    bit found;
    int n;
    logic [7:0] e;
    logic [31:0] old_disp;
    logic [7:0]  old_dp;
    logic        old_ov;
    old_disp = cur_disp; old_dp = cur_dp; old_ov = cur_ov;
    cur_disp = dec_digits(v); cur_dp = dp; cur_ov = (v >= 32'd100000000);
    push_display();
    do_write(v, 1'b1, dp);
    n = 1;
    if (second_wr) begin
      @(negedge clk); n++;
      do_write(32'h0000_0000, 1'b0, 8'hFF);
      n += 2;
    end
    while (busy === 1'b1 && n < 200) begin
      if (n == 16) begin
        // Display must still show the previous value mid-conversion.
        found = 1'b0;
        for (int d = 0; d < ND; d++) begin
          if (SSEG_AN === ~(8'd1 << d)) begin
            found = 1'b1;
            e = exp_ca(old_disp, old_dp, old_ov, d);
            checks++;
            if (SSEG_CA !== e) begin errors++; $display("FAIL %s_hold_digit%0d: got %h expected %h", name, d, SSEG_CA, e); end
          end
        end
        if (!found) begin checks++; errors++; $display("FAIL %s_hold_an: got %h expected one-hot low", name, SSEG_AN); end
      end
      @(negedge clk);
      n++;
    end
    checks++;
    if (n != 34) begin errors++; $display("FAIL %s_busy_span: got %0d expected 34", name, n); end
    checks++;
    if (ovf !== cur_ov) begin errors++; $display("FAIL %s_ovf: got %b expected %b", name, ovf, cur_ov); end
    collect_scan(ca, to);
    checks++; if (to) begin errors++; $display("FAIL %s_scan_timeout: got timeout expected all digits", name); end
    for (int d = 0; d < ND; d++) begin
      e = exp_q.pop_front();
      checks++;
      if (ca[d] !== e) begin errors++; $display("FAIL %s_digit%0d: got %h expected %h", name, d, ca[d], e); end
    end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL %s_busy_after: got %b expected 0", name, busy); end
  endtask

  task automatic test_reset_mid_conv();
    logic [7:0][7:0] ca;
    bit to;
    bit rose;
    logic [7:0] e;
    do_write(32'd99, 1'b1, 8'h00);
    repeat (8) @(negedge clk);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL midrst_busy_pre: got %b expected 1", busy); end
    n_rst = 1'b0;
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midrst_busy: got %b expected 0", busy); end
    checks++; if (SSEG_AN !== 8'hFF || SSEG_CA !== 8'hFF) begin
      errors++; $display("FAIL midrst_out: got an=%h ca=%h expected ff ff", SSEG_AN, SSEG_CA); end
    cur_disp = '0; cur_dp = '0; cur_ov = 1'b0;
    push_display();
    @(negedge clk);
    n_rst = 1'b1;
    rose = 1'b0;
    repeat (50) begin
      @(negedge clk);
      if (busy !== 1'b0 || ovf !== 1'b0) rose = 1'b1;
    end
    checks++; if (rose) begin errors++; $display("FAIL midrst_no_commit: got busy/ovf activity expected none"); end
    collect_scan(ca, to);
    checks++; if (to) begin errors++; $display("FAIL midrst_scan_timeout: got timeout expected all digits"); end
    for (int d = 0; d < ND; d++) begin
      e = exp_q.pop_front();
      checks++;
      if (ca[d] !== e) begin errors++; $display("FAIL midrst_digit%0d: got %h expected %h", d, ca[d], e); end
    end
  endtask

`ifdef SSEG_LZ_BLANK_EN
  task automatic test_lz_blank();
    logic [7:0][7:0] ca;
    bit to;
    logic [7:0] want [8];
    test_decimal(32'd42, 8'h00, 1'b0, "lz42");
    want = '{8'hA4, 8'h99, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
    collect_scan(ca, to);
    checks++; if (to) begin errors++; $display("FAIL lz_scan_timeout: got timeout expected all digits"); end
    for (int d = 0; d < ND; d++) begin
      checks++;
      if (ca[d] !== want[d]) begin errors++; $display("FAIL lz_digit%0d: got %h expected %h", d, ca[d], want[d]); end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_hex(32'hDEADBEEF, 8'h01, "hex_deadbeef");
    test_decimal(32'd12345678, 8'h10, 1'b0, "dec_12345678");
    test_decimal(32'd100000000, 8'h00, 1'b0, "dec_ovf");
    test_hex(32'h0123ABCD, 8'hF0, "hex_after_ovf");
    test_decimal(32'd87654321, 8'h00, 1'b1, "dec_ignore2nd");
    test_reset_mid_conv();
`ifdef SSEG_LZ_BLANK_EN
    test_lz_blank();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
